// File: rtl/hs_earom_seq.sv
// hs_earom_seq: EAROM access sequencer.
// Runs read, write, erase and erase-then-write cycles against an EAROM.
// Each cycle drives address, data and mode for a setup period, pulses
// ea_clk, and then for write/erase holds the program mode before
// releasing the chip. A single 16-bit down-counter times every state.
// A pending-write flag chains the write phase behind the erase phase
// of op 3.
module hs_earom_seq #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    parameter int WRITE_CYC = 8,
    parameter int ERASE_CYC = 10
) (
    input  logic       clk_cpu_4x,
    input  logic       reset_cpu,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [5:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [5:0] ea_addr,
    output logic [7:0] ea_din,
    input  logic [7:0] ea_dout,
    output logic       ea_clk,
    output logic       ea_c1,
    output logic       ea_c2,
    output logic       ea_cs1
);

    // A zero duration is promoted to one cycle. An oversized duration is
    // clipped so that it still fits the 16-bit counter.
    function automatic logic [15:0] clamp_cyc(input int n);
        if (n <= 0)
            return 16'd1;
        else if (n > 65535)
            return 16'hFFFF;
        else
            return n[15:0];
    endfunction

    localparam logic [15:0] SETUP_N = clamp_cyc(SETUP_CYC);
    localparam logic [15:0] PULSE_N = clamp_cyc(PULSE_CYC);
    localparam logic [15:0] WRITE_N = clamp_cyc(WRITE_CYC);
    localparam logic [15:0] ERASE_N = clamp_cyc(ERASE_CYC);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_ERASE = 2'd2;
    localparam logic [1:0] OP_ERWR  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        PROG   = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        pend, pend_nxt;
    logic [1:0]  op_q;
    logic        accept;
    logic        read_cap;
    logic        erase_phase;
    logic [15:0] prog_n;

    // The erase phase is a plain erase, or op 3 while its write is still pending.
    assign erase_phase = (op_q == OP_ERASE) || ((op_q == OP_ERWR) && pend);
    assign prog_n      = erase_phase ? ERASE_N : WRITE_N;

    // Sample read data on the edge that leaves the strobe of a read.
    assign read_cap = (state == STROBE) && (cnt == 16'd0) && (op_q == OP_READ);

    // State register, duration counter and pending-write flag.
    always_ff @(posedge clk_cpu_4x or posedge reset_cpu) begin
        if (reset_cpu) begin
            state <= IDLE;
            cnt   <= 16'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    // Latch the request fields on acceptance and capture the read result.
    always_ff @(posedge clk_cpu_4x or posedge reset_cpu) begin
        if (reset_cpu) begin
            op_q    <= OP_READ;
            ea_addr <= 6'd0;
            ea_din  <= 8'd0;
            rdata   <= 8'd0;
        end else begin
            if (accept) begin
                op_q    <= op;
                ea_addr <= addr;
                ea_din  <= wdata;
            end
            if (read_cap)
                rdata <= ea_dout;
        end
    end

    // Next state and counter. Each state loads (duration - 1) on entry and
    // moves on when the counter reaches zero, so the counter never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_N - 16'd1;
                    pend_nxt  = (op == OP_ERWR);
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 16'd0;
                end
            end
            SETUP: begin
                if (cnt == 16'd0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = PULSE_N - 16'd1;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            STROBE: begin
                if (cnt == 16'd0) begin
                    if (op_q == OP_READ) begin
                        state_nxt = HOLD;
                        cnt_nxt   = 16'd0;
                    end else begin
                        state_nxt = PROG;
                        cnt_nxt   = prog_n - 16'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            PROG: begin
                if (cnt == 16'd0) begin
                    if (pend) begin
                        // Erase of op 3 is complete; start its write phase.
                        state_nxt = SETUP;
                        cnt_nxt   = SETUP_N - 16'd1;
                        pend_nxt  = 1'b0;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = 16'd0;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            HOLD: begin
                state_nxt = DONE;
                cnt_nxt   = 16'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 16'd0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    // Decode the EAROM strobes, the mode bits and the status outputs from the state.
    // Being combinational, they drop as soon as reset forces IDLE.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        ea_clk = 1'b0;
        ea_cs1 = 1'b0;
        ea_c1  = 1'b1;
        ea_c2  = 1'b1;
        case (state)
            SETUP, STROBE, PROG: begin
                busy   = 1'b1;
                ea_cs1 = 1'b1;
                ea_clk = (state == STROBE);
                case (op_q)
                    OP_READ:  begin ea_c1 = 1'b1; ea_c2 = 1'b0; end
                    OP_WRITE: begin ea_c1 = 1'b0; ea_c2 = 1'b0; end
                    OP_ERASE: begin ea_c1 = 1'b0; ea_c2 = 1'b1; end
                    default:  begin ea_c1 = 1'b0; ea_c2 = pend;  end
                endcase
            end
            HOLD: begin
                busy   = 1'b1;
                ea_cs1 = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hs_earom_seq.sv
// tb_hs_earom_seq: checks hs_earom_seq cycle by cycle against a trace model.
// The model expands each operation into per-cycle expected output vectors.
// It works from the phase durations and the mode encoding of each phase.
module tb_hs_earom_seq;

    localparam int S = 2;
    localparam int P = 3;
    localparam int W = 8;
    localparam int E = 10;

    logic       clk_cpu_4x = 1'b0;
    logic       reset_cpu  = 1'b1;
    logic       req = 1'b0;
    logic [1:0] op = 2'd0;
    logic [5:0] addr = 6'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] ea_dout = 8'd0;
    logic       busy, done, ea_clk, ea_c1, ea_c2, ea_cs1;
    logic [7:0] rdata, ea_din;
    logic [5:0] ea_addr;

    logic       z_req = 1'b0;
    logic [1:0] z_op = 2'd0;
    logic [5:0] z_addr = 6'd0;
    logic [7:0] z_wdata = 8'd0;
    logic [7:0] z_dout = 8'd0;
    logic       z_busy, z_done, z_ea_clk, z_ea_c1, z_ea_c2, z_ea_cs1;
    logic [7:0] z_rdata, z_ea_din;
    logic [5:0] z_ea_addr;

    always #5 clk_cpu_4x = ~clk_cpu_4x;

    hs_earom_seq u_dut (
        .clk_cpu_4x(clk_cpu_4x), .reset_cpu(reset_cpu), .req(req), .op(op),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .ea_addr(ea_addr), .ea_din(ea_din), .ea_dout(ea_dout), .ea_clk(ea_clk),
        .ea_c1(ea_c1), .ea_c2(ea_c2), .ea_cs1(ea_cs1)
    );

    hs_earom_seq #(.SETUP_CYC(0), .PULSE_CYC(0)) u_dut_z (
        .clk_cpu_4x(clk_cpu_4x), .reset_cpu(reset_cpu), .req(z_req), .op(z_op),
        .addr(z_addr), .wdata(z_wdata), .busy(z_busy), .done(z_done), .rdata(z_rdata),
        .ea_addr(z_ea_addr), .ea_din(z_ea_din), .ea_dout(z_dout), .ea_clk(z_ea_clk),
        .ea_c1(z_ea_c1), .ea_c2(z_ea_c2), .ea_cs1(z_ea_cs1)
    );

    // {busy, done, ea_clk, ea_cs1, ea_c1, ea_c2}
    logic [5:0] outs;
    assign outs = {busy, done, ea_clk, ea_cs1, ea_c1, ea_c2};
    localparam logic [5:0] IDLE_V = 6'b000011;

    int         vec_cnt  = 0;
    int         miss_cnt = 0;
    logic [7:0] m_rdata  = 8'd0;
    logic [5:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_n(input int n, input logic [5:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endfunction

    // One access phase: setup, strobe, then program hold, all in mode m.
    function automatic void phase(input logic [1:0] m, input int prog);
        push_n(S, {4'b1001, m});
        push_n(P, {4'b1011, m});
        push_n(prog, {4'b1001, m});
    endfunction

    // Expected outputs for every cycle after the acceptance edge, up to and including DONE.
    function automatic void build(input logic [1:0] o);
        exp_q.delete();
        case (o)
            2'd0: begin
                push_n(S, 6'b100110);
                push_n(P, 6'b101110);
            end
            2'd1: phase(2'b00, W);
            2'd2: phase(2'b01, E);
            default: begin
                phase(2'b01, E);
                phase(2'b00, W);
            end
        endcase
        push_n(1, 6'b100111);
        push_n(1, 6'b010011);
    endfunction

    // Issue one operation and check every cycle until DONE. With chain=1 the
    // task returns on the DONE cycle so the next call requests during DONE.
    // When poke is in range, a stray read request is raised on that cycle.
    task automatic run_op(input logic [1:0] o, input logic [5:0] a, input logic [7:0] w,
                          input logic [7:0] dout, input bit chain, input int poke,
                          output int lat);
        int pk;
        req = 1'b1; op = o; addr = a; wdata = w; ea_dout = dout;
        build(o);
        pk = (poke >= 0 && poke < exp_q.size() - 1) ? poke : -1;
        if (o == 2'd0) m_rdata = dout;
        lat = -1;
        @(posedge clk_cpu_4x);
        @(negedge clk_cpu_4x);
        req = 1'b0; op = 2'($urandom); addr = 6'($urandom); wdata = 8'($urandom);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk_cpu_4x);
            chk($sformatf("ctl[op%0d,c%0d]", o, k), 32'(outs), 32'(exp_q[k]));
            if (exp_q[k][5]) begin
                chk("ea_addr", 32'(ea_addr), 32'(a));
                chk("ea_din", 32'(ea_din), 32'(w));
            end
            if (done && lat < 0) lat = k;
            if (k == pk) begin
                req = 1'b1; op = 2'd0; addr = 6'($urandom);
            end else if (k == pk + 1) begin
                req = 1'b0;
            end
        end
        chk("rdata", 32'(rdata), 32'(m_rdata));
        if (!chain) begin
            @(negedge clk_cpu_4x);
            chk("idle_after", 32'(outs), 32'(IDLE_V));
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] dout;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int lat;
        int zk;
        int zhi;
        tbl[0] = '{2'd0, 6'h2A, 8'h00, 8'h5C, 8'h5C, 6};
        tbl[1] = '{2'd1, 6'h05, 8'hA7, 8'hFF, 8'h5C, 14};
        tbl[2] = '{2'd3, 6'h3F, 8'h11, 8'h00, 8'h5C, 29};
        tbl[3] = '{2'd2, 6'h10, 8'h00, 8'h33, 8'h5C, 16};
        tbl[4] = '{2'd0, 6'h01, 8'h00, 8'hE1, 8'hE1, 6};

        // Reset state
        #2;
        chk("rst_ctl", 32'(outs), 32'(IDLE_V));
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_addr", 32'(ea_addr), 32'd0);
        chk("rst_din", 32'(ea_din), 32'd0);
        @(negedge clk_cpu_4x);
        reset_cpu = 1'b0;
        @(negedge clk_cpu_4x);

        // Table-driven directed operations
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].dout, 1'b0, -1, lat);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].exp_rdata));
        end

        // A request during PROG is ignored
        run_op(2'd1, 6'h22, 8'h5A, 8'h00, 1'b0, S + P + 2, lat);
        chk("ignore_lat", 32'(lat), 32'(S + P + W + 1));

        // A request held during DONE starts the next operation with no gap
        run_op(2'd0, 6'h07, 8'h00, 8'h9E, 1'b1, -1, lat);
        run_op(2'd1, 6'h08, 8'hC3, 8'h00, 1'b1, -1, lat);
        run_op(2'd0, 6'h09, 8'h00, 8'h4B, 1'b0, -1, lat);
        chk("b2b_lat", 32'(lat), 32'(S + P + 1));

        // Randomized operations, with random chaining and stray requests
        for (int r = 0; r < 14; r++) begin
            run_op(2'($urandom), 6'($urandom), 8'($urandom), 8'($urandom),
                   (r != 13) && ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1, lat);
        end

        // Reset during the strobe of a write aborts at once
        req = 1'b1; op = 2'd1; addr = 6'h15; wdata = 8'h3C;
        @(posedge clk_cpu_4x);
        @(negedge clk_cpu_4x);
        req = 1'b0;
        repeat (2) @(negedge clk_cpu_4x);
        chk("pre_rst_strobe", 32'(outs), 32'b101100);
        #1 reset_cpu = 1'b1;
        m_rdata = 8'd0;
        #1;
        chk("rst_abort_ctl", 32'(outs), 32'(IDLE_V));
        chk("rst_abort_rdata", 32'(rdata), 32'd0);
        chk("rst_abort_addr", 32'(ea_addr), 32'd0);
        #1 reset_cpu = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_cpu_4x);
            chk("post_rst_idle", 32'(outs), 32'(IDLE_V));
        end
        run_op(2'd0, 6'h2B, 8'h00, 8'hD7, 1'b0, -1, lat);
        chk("post_rst_read_lat", 32'(lat), 32'(S + P + 1));
        chk("post_rst_read_data", 32'(rdata), 32'hD7);

        // Zero setup and pulse parameters behave as one cycle each
        z_req = 1'b1; z_op = 2'd0; z_addr = 6'h11; z_dout = 8'h9D;
        @(posedge clk_cpu_4x);
        @(negedge clk_cpu_4x);
        z_req = 1'b0;
        zk  = 0;
        zhi = 0;
        while (!z_done && zk < 20) begin
            if (z_ea_clk) zhi++;
            @(negedge clk_cpu_4x);
            zk++;
        end
        chk("z_done_lat", 32'(zk), 32'd3);
        chk("z_strobe_len", 32'(zhi), 32'd1);
        chk("z_rdata", 32'(z_rdata), 32'h9D);
        chk("z_addr", 32'(z_ea_addr), 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/hs_earom_seq.md
HS_EAROM_SEQ -- requirements
Module: hs_earom_seq

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, address/data/mode setup cycles before strobe (0 treated as 1).
REQ-002 SHALL have parameter PULSE_CYC, default 3, ea_clk high-pulse cycles (0 treated as 1).
REQ-003 SHALL have parameter WRITE_CYC, default 8, program hold cycles after write strobe (0 treated as 1).
REQ-004 SHALL have parameter ERASE_CYC, default 10, program hold cycles after erase strobe (0 treated as 1).
REQ-005 SHALL have ports, clock and reset first:
- clk_cpu_4x  in  1  sole clock, rising edge.
- reset_cpu  in  1  asynchronous, active-high reset.
- req  in  1  operation request, sampled every edge.
- op  in  2  0 read, 1 write, 2 erase, 3 erase-then-write.
- addr  in  6  EAROM cell address.
- wdata  in  8  write data.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  8  last read result.
- ea_addr  out  6  to EAROM address.
- ea_din  out  8  to EAROM data in.
- ea_dout  in  8  from EAROM data out.
- ea_clk, ea_c1, ea_c2, ea_cs1  out  1 each  EAROM strobe, mode bits, chip select.

Function
REQ-006 SHALL be a single FSM: IDLE, SETUP, STROBE, PROG, HOLD, DONE, plus a 16-bit down-counter for state duration and a 1-bit pending-write flag.
REQ-007 SHALL accept a request on an edge where req=1 and state is IDLE or DONE; addr, wdata, op latched that edge; next state SETUP.
REQ-008 SHALL ignore req in all other states; no queuing.
REQ-009 SHALL hold each of SETUP, STROBE, PROG for exactly its parameter count of cycles; HOLD and DONE exactly 1 cycle each.
REQ-010 Read path SHALL be SETUP -> STROBE -> HOLD -> DONE; write/erase path SHALL be SETUP -> STROBE -> PROG -> HOLD -> DONE.
REQ-011 op=3 SHALL run the erase path up to PROG, then SETUP -> STROBE -> PROG with write mode, then HOLD -> DONE; pending-write flag selects the phase.
REQ-012 Mode encoding (c1,c2) SHALL be: standby (1,1), read (1,0), write (0,0), erase (0,1); driven from SETUP through PROG, standby otherwise.
REQ-013 ea_cs1 SHALL be 1 in SETUP, STROBE, PROG, HOLD, else 0; ea_clk SHALL be 1 only in STROBE.
REQ-014 ea_addr and ea_din SHALL be the latched values, stable from SETUP through HOLD.
REQ-015 rdata SHALL capture ea_dout on the edge leaving STROBE for a read; unchanged by write/erase.
REQ-016 busy SHALL be 1 in SETUP, STROBE, PROG, HOLD, else 0; done SHALL be 1 only in DONE.
REQ-017 Latency SHALL be: read done at acceptance edge + SETUP+PULSE+1; write/erase + SETUP+PULSE+PROG+1; op=3 + 2*(SETUP+PULSE)+ERASE+WRITE+1.
REQ-018 req=1 during DONE SHALL be accepted: done still pulses that cycle, next state SETUP, no IDLE gap.
REQ-019 Counter SHALL never wrap: loads (count-1) on state entry, transitions at zero.

Reset
REQ-020 reset_cpu=1 SHALL asynchronously force IDLE, counter 0, pending flag 0, busy 0, done 0, rdata 0x00, ea_addr 0, ea_din 0, ea_clk 0, ea_cs1 0, ea_c1 1, ea_c2 1.
REQ-021 Reset mid-sequence SHALL abort immediately (strobe and chip select drop that instant); no done pulse follows.

Verification
REQ-022 Read: defaults, req op=0 addr=0x2A, ea_dout=0x5C -> ea_clk high 3 cycles, c1c2=10, done at edge+6, rdata=0x5C.
REQ-023 Write: req op=1 addr=0x05 wdata=0xA7 -> ea_din=0xA7, c1c2=00, done at edge+14, rdata unchanged.
REQ-024 Erase-then-write: req op=3 addr=0x3F wdata=0x11 -> two ea_clk pulses, c1c2 01 then 00, cs1 continuous, done at edge+29.
REQ-025 Busy ignore / back-to-back: req during PROG ignored; req held during DONE -> second sequence starts next cycle, done pulses once per operation.
REQ-026 Reset during STROBE of write -> ea_clk, ea_cs1, busy 0 immediately, c1c2=11, no done; next read completes normally.
REQ-027 Parameters 0: SETUP_CYC=0, PULSE_CYC=0 read -> behaves as 1 each, done at edge+3.
